// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, opcodes, functs, ALU codes, mux selects.
// MCTRL_IMM_EN adds the immediate-ALU states and opcodes.
package mcpu_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SRC_B_W  = 2;
    localparam int unsigned PC_SRC_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_ALU_WB    = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9
`ifdef MCTRL_IMM_EN
        ,
        ST_IMM_EXEC  = 4'd10,
        ST_IMM_WB    = 4'd11
`endif
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'b1111;

    localparam logic [SRC_B_W-1:0] SRC_B_REG    = 2'd0;
    localparam logic [SRC_B_W-1:0] SRC_B_FOUR   = 2'd1;
    localparam logic [SRC_B_W-1:0] SRC_B_IMM    = 2'd2;
    localparam logic [SRC_B_W-1:0] SRC_B_IMM_SH = 2'd3;

    localparam logic [PC_SRC_W-1:0] PC_SRC_ALU     = 2'd0;
    localparam logic [PC_SRC_W-1:0] PC_SRC_ALU_OUT = 2'd1;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP    = 2'd2;

    // ALU operation for an immediate-format opcode; zero-extension for andi/ori lives in the datapath.
    function automatic logic [ALU_OP_W-1:0] imm_alu_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDI: imm_alu_op = ALU_ADD;
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            default: imm_alu_op = ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational R-type funct -> ALU operation mapping with legality flag.
module alu_op_decode
    import mcpu_pkg::*;
(
    input  logic [FUNCT_W-1:0]  funct_i,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                legal_o
);

    always_comb begin
        alu_op_o = ALU_NOP;
        legal_o  = 1'b1;
        case (funct_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_SLT:  alu_op_o = ALU_SLT;
            FN_NOR:  alu_op_o = ALU_NOR;
            default: legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control FSM; outputs are decoded from the current state.
// Define MCTRL_IMM_EN to support addi/andi/ori through the IMM_EXEC/IMM_WB states.
module multi_cycle_ctrl
    import mcpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                alu_src_a,
    output logic [SRC_B_W-1:0]  alu_src_b,
    output logic [PC_SRC_W-1:0] pc_source,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [STATE_W-1:0]  state,
    output logic                illegal
);

    state_e              state_q;
    state_e              state_d;
    logic [ALU_OP_W-1:0] funct_alu_op;
    logic                funct_legal;
    logic                unused_alu_zero;

    alu_op_decode u_alu_op_decode (
        .funct_i  (funct),
        .alu_op_o (funct_alu_op),
        .legal_o  (funct_legal)
    );

    // Branch gating with alu_zero happens at the PC write enable, outside this block.
    assign unused_alu_zero = alu_zero;
    assign state           = STATE_W'(state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        pc_source     = PC_SRC_ALU;
        alu_op        = ALU_NOP;
        illegal       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRC_B_IMM_SH;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
`ifdef MCTRL_IMM_EN
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = ST_IMM_EXEC;
`else
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_ADD;
                state_d   = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end
            end
            ST_MEM_WRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
            end
            // An unknown funct is only discovered here, so the illegal pulse comes from EXECUTE.
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_REG;
                alu_op    = funct_alu_op;
                if (funct_legal) begin
                    state_d = ST_ALU_WB;
                end else begin
                    illegal = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRC_B_REG;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALU_OUT;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
                state_d   = ST_FETCH;
            end
`ifdef MCTRL_IMM_EN
            ST_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_op    = imm_alu_op(opcode);
                state_d   = ST_IMM_WB;
            end
            ST_IMM_WB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
`endif
            default: state_d = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: instruction-level cycle model, directed table, corner sequences, random mix.
module tb_multi_cycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write;
    logic       mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic [3:0] state;
    logic       illegal;

    multi_cycle_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct         (funct),
        .alu_zero      (alu_zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .state         (state),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_SLT = 4'b0111;
    localparam logic [3:0] A_NOR = 4'b1100;
    localparam logic [3:0] A_NOP = 4'b1111;

    // Expected vector: {state, pcw,pcwc,iord,mr,mw,irw,rw, m2r,rdst,srca,srcb[1:0],pcs[1:0], alu_op, illegal}
    typedef struct {
        logic [22:0] exp;
        logic [22:0] care;
        logic        rdy;
        logic [5:0]  op;
        logic [5:0]  fn;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         fw;
        int         mw;
        int         lat;
        int         ill;
        int         rw;
    } vec_t;

    cyc_t q[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   obs_busy, obs_ill, obs_rw;
    logic [5:0] legal_fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [3:0] st, input logic [6:0] strb, input logic [3:0] aop,
                                 input logic ill, input logic [6:0] sv, input logic [6:0] sc,
                                 input logic rdy, input logic [5:0] op, input logic [5:0] fn);
        cyc_t c;
        c.exp  = {st, strb, sv, aop, ill};
        c.care = {4'hF, 7'h7F, sc, 4'hF, 1'b1};
        c.rdy  = rdy;
        c.op   = op;
        c.fn   = fn;
        q.push_back(c);
    endfunction

    function automatic logic [3:0] ref_alu(input logic [5:0] fn, output logic ok);
        ok = 1'b1;
        case (fn)
            6'b100000: ref_alu = A_ADD;
            6'b100010: ref_alu = A_SUB;
            6'b100100: ref_alu = A_AND;
            6'b100101: ref_alu = A_OR;
            6'b101010: ref_alu = A_SLT;
            6'b100111: ref_alu = A_NOR;
            default: begin
                ref_alu = A_NOP;
                ok      = 1'b0;
            end
        endcase
    endfunction

    function automatic void push_decode(input logic ill, input logic [5:0] op, input logic [5:0] fn);
        push(4'd1, 7'b0000000, A_ADD, ill, 7'b0001100, 7'b0011100, rnd_bit(), op, fn);
    endfunction

    // Cycle-by-cycle expectation for one instruction, from fetch to its last cycle.
    function automatic void gen_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        logic [3:0] aop;
        logic       ok;
        for (int i = 0; i < fw; i++)
            push(4'd0, 7'b0001000, A_ADD, 1'b0, 7'b0000100, 7'b0011100, 1'b0, op, fn);
        push(4'd0, 7'b1001010, A_ADD, 1'b0, 7'b0000100, 7'b0011100, 1'b1, op, fn);
        case (op)
            6'b100011, 6'b101011: begin
                push_decode(1'b0, op, fn);
                push(4'd2, 7'b0000000, A_ADD, 1'b0, 7'b0011000, 7'b0011100, rnd_bit(), op, fn);
                if (op == 6'b100011) begin
                    for (int i = 0; i < mw; i++)
                        push(4'd3, 7'b0011000, A_NOP, 1'b0, 7'b0, 7'b0, 1'b0, op, fn);
                    push(4'd3, 7'b0011000, A_NOP, 1'b0, 7'b0, 7'b0, 1'b1, op, fn);
                    push(4'd4, 7'b0000001, A_NOP, 1'b0, 7'b1000000, 7'b1100000, rnd_bit(), op, fn);
                end else begin
                    for (int i = 0; i < mw; i++)
                        push(4'd5, 7'b0010100, A_NOP, 1'b0, 7'b0, 7'b0, 1'b0, op, fn);
                    push(4'd5, 7'b0010100, A_NOP, 1'b0, 7'b0, 7'b0, 1'b1, op, fn);
                end
            end
            6'b000000: begin
                push_decode(1'b0, op, fn);
                aop = ref_alu(fn, ok);
                push(4'd6, 7'b0000000, aop, !ok, 7'b0010000, 7'b0011100, rnd_bit(), op, fn);
                if (ok)
                    push(4'd7, 7'b0000001, A_NOP, 1'b0, 7'b0100000, 7'b1100000, rnd_bit(), op, fn);
            end
            6'b000100: begin
                push_decode(1'b0, op, fn);
                push(4'd8, 7'b0100000, A_SUB, 1'b0, 7'b0010001, 7'b0011111, rnd_bit(), op, fn);
            end
            6'b000010: begin
                push_decode(1'b0, op, fn);
                push(4'd9, 7'b1000000, A_NOP, 1'b0, 7'b0000010, 7'b0000011, rnd_bit(), op, fn);
            end
            6'b001000, 6'b001100, 6'b001101: begin
`ifdef MCTRL_IMM_EN
                push_decode(1'b0, op, fn);
                aop = (op == 6'b001000) ? A_ADD : ((op == 6'b001100) ? A_AND : A_OR);
                push(4'd10, 7'b0000000, aop, 1'b0, 7'b0011000, 7'b0011100, rnd_bit(), op, fn);
                push(4'd11, 7'b0000001, A_NOP, 1'b0, 7'b0000000, 7'b1100000, rnd_bit(), op, fn);
`else
                push_decode(1'b1, op, fn);
`endif
            end
            default: push_decode(1'b1, op, fn);
        endcase
    endfunction

    function automatic void add_vec(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                                    input int lat, input int ill, input int rw);
        vec_t v;
        v.op = op; v.fn = fn; v.fw = fw; v.mw = mw; v.lat = lat; v.ill = ill; v.rw = rw;
        vecs.push_back(v);
    endfunction

    // Entered and left just after a falling edge.
    task automatic run_queue();
        cyc_t        c;
        logic [22:0] act;
        while (q.size() > 0) begin
            c         = q.pop_front();
            opcode    = c.op;
            funct     = c.fn;
            mem_ready = c.rdy;
            alu_zero  = rnd_bit();
            #1;
            act = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
                   mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_source, alu_op, illegal};
            total++;
            if ((act & c.care) !== (c.exp & c.care)) begin
                bad++;
                $display("FAIL ctrl_vec t=%0t op=%b fn=%b: got=%h want=%h care=%h",
                         $time, c.op, c.fn, act & c.care, c.exp & c.care, c.care);
            end
            total++;
            if (int'(mem_read) + int'(mem_write) + int'(reg_write) > 1) begin
                bad++;
                $display("FAIL excl t=%0t: mr=%b mw=%b rw=%b want at most one high",
                         $time, mem_read, mem_write, reg_write);
            end
            if (state != 4'd0) obs_busy++;
            if (illegal === 1'b1) obs_ill++;
            if (reg_write === 1'b1) obs_rw++;
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [5:0] op, fn;
        int         k;

        rst = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0; alu_zero = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Still in reset: FETCH decode with mem_ready high.
        push(4'd0, 7'b1001010, A_ADD, 1'b0, 7'b0000100, 7'b0011100, 1'b1, 6'b0, 6'b0);
        run_queue();
        rst = 1'b0;

        add_vec(6'b000000, 6'b101010, 0, 0, 4, 0, 1);
        add_vec(6'b000000, 6'b100000, 1, 0, 4, 0, 1);
        add_vec(6'b000000, 6'b100010, 0, 0, 4, 0, 1);
        add_vec(6'b000000, 6'b100100, 2, 0, 4, 0, 1);
        add_vec(6'b000000, 6'b100101, 0, 0, 4, 0, 1);
        add_vec(6'b000000, 6'b100111, 0, 0, 4, 0, 1);
        add_vec(6'b000000, 6'b000111, 0, 0, 3, 1, 0);
        add_vec(6'b100011, 6'b000000, 0, 3, 5, 0, 1);
        add_vec(6'b100011, 6'b000000, 1, 0, 5, 0, 1);
        add_vec(6'b101011, 6'b000000, 0, 2, 4, 0, 0);
        add_vec(6'b000100, 6'b000000, 0, 0, 3, 0, 0);
        add_vec(6'b000010, 6'b000000, 0, 0, 3, 0, 0);
        add_vec(6'b111111, 6'b000000, 0, 0, 2, 1, 0);
`ifdef MCTRL_IMM_EN
        add_vec(6'b001000, 6'b000000, 0, 0, 4, 0, 1);
        add_vec(6'b001100, 6'b000000, 0, 0, 4, 0, 1);
        add_vec(6'b001101, 6'b000000, 0, 0, 4, 0, 1);
`else
        add_vec(6'b001000, 6'b000000, 0, 0, 2, 1, 0);
        add_vec(6'b001101, 6'b000000, 0, 0, 2, 1, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            obs_busy = 0; obs_ill = 0; obs_rw = 0;
            gen_instr(vecs[i].op, vecs[i].fn, vecs[i].fw, vecs[i].mw);
            run_queue();
            total++;
            if (obs_busy + 1 != vecs[i].lat + vecs[i].mw) begin
                bad++;
                $display("FAIL latency vec%0d op=%b: got=%0d want=%0d", i, vecs[i].op,
                         obs_busy + 1, vecs[i].lat + vecs[i].mw);
            end
            total++;
            if (obs_ill != vecs[i].ill) begin
                bad++;
                $display("FAIL illegal_pulses vec%0d: got=%0d want=%0d", i, obs_ill, vecs[i].ill);
            end
            total++;
            if (obs_rw != vecs[i].rw) begin
                bad++;
                $display("FAIL reg_write_cycles vec%0d: got=%0d want=%0d", i, obs_rw, vecs[i].rw);
            end
        end

        // Reset while a store is waiting on memory.
        push(4'd0, 7'b1001010, A_ADD, 1'b0, 7'b0000100, 7'b0011100, 1'b1, 6'b101011, 6'b0);
        push_decode(1'b0, 6'b101011, 6'b0);
        push(4'd2, 7'b0000000, A_ADD, 1'b0, 7'b0011000, 7'b0011100, 1'b0, 6'b101011, 6'b0);
        push(4'd5, 7'b0010100, A_NOP, 1'b0, 7'b0, 7'b0, 1'b0, 6'b101011, 6'b0);
        push(4'd5, 7'b0010100, A_NOP, 1'b0, 7'b0, 7'b0, 1'b0, 6'b101011, 6'b0);
        run_queue();
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        total++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_wait: got state=%0d mw=%b want state=5 mw=1", state, mem_write);
        end
        @(negedge clk);
        #1;
        total++;
        if (state !== 4'd0 || mem_write !== 1'b0 || mem_read !== 1'b1 || ir_write !== 1'b0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_write: got state=%0d mw=%b mr=%b irw=%b ill=%b want 0/0/1/0/0",
                     state, mem_write, mem_read, ir_write, illegal);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 80; n++) begin
            k  = int'($urandom_range(0, 9));
            fn = 6'($urandom);
            case (k)
                0, 9: begin op = 6'b000000; fn = legal_fn[$urandom_range(0, 5)]; end
                1:    op = 6'b000000;
                2, 8: op = 6'b100011;
                3:    op = 6'b101011;
                4:    op = 6'b000100;
                5:    op = 6'b000010;
                6: begin
                    case ($urandom_range(0, 2))
                        0:       op = 6'b001000;
                        1:       op = 6'b001100;
                        default: op = 6'b001101;
                    endcase
                end
                default: op = 6'($urandom);
            endcase
            gen_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            run_queue();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
